pwm_peripheral: RTL and testbench

Downstream consumer of the SPI register bank. Takes the five control bytes written over SPI, brings them safely into the system clock domain, and drives 16 output pins. Each pin is off, statically on, or PWM-modulated at a shared duty cycle. Duty changes are applied only at PWM period boundaries so every period on the pins is glitch-free.

---
 rtl/pwm_peripheral.sv | 117 +++++++++++
 tb/tb_pwm_peripheral.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Consumes the five SPI control bytes, filters them into the clk domain and
//   drives 16 pins that are off, statically on, or PWM-modulated at a shared
//   duty cycle. Duty updates take effect only at PWM period boundaries.
//
// Parameters
//   CLK_DIV          system clocks per PWM counter step (1..4095)
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enable, pins 7:0     (SCLK domain, quasi-static)
//   en_reg_out_15_8  output enable, pins 15:8
//   en_reg_pwm_7_0   PWM select, pins 7:0
//   en_reg_pwm_15_8  PWM select, pins 15:8
//   pwm_duty_cycle   shared duty, 0x00 = low, 0xFF = always high
//   out              registered pin drive
//   period_start     one-clock pulse when the PWM counter wraps to 0
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned      PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [39:0]      in_vec;
  logic [39:0]      cap_a_q, cap_a_d;
  logic [39:0]      cap_b_q, cap_b_d;
  logic [39:0]      stable_q, stable_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       active_duty_q, active_duty_d;
  logic [15:0]      out_q, out_d;
  logic             period_start_q, period_start_d;

  logic             tick;
  logic             boundary;
  logic             pwm;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [7:0]       duty_in;

  assign in_vec  = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                    en_reg_out_15_8, en_reg_out_7_0};
  assign en_out  = stable_q[15:0];
  assign en_pwm  = stable_q[31:16];
  assign duty_in = stable_q[39:32];

  always_comb begin
    cap_a_d        = in_vec;
    cap_b_d        = cap_a_q;
    stable_d       = stable_q;
    pre_d          = pre_q + PRE_W'(1);
    cnt_d          = cnt_q;
    active_duty_d  = active_duty_q;
    period_start_d = 1'b0;
    tick           = (pre_q == PRE_LAST);
    boundary       = 1'b0;

    // Two consecutive identical samples mean the SPI side is not mid-update,
    // so the whole 40-bit word is accepted at once; a torn word never is.
    if (cap_a_q == cap_b_q) begin
      stable_d = cap_b_q;
    end

    if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == 8'hFF) begin
        boundary = 1'b1;
      end
    end

    if (boundary) begin
      active_duty_d  = duty_in;
      period_start_d = 1'b1;
    end

    pwm   = (active_duty_q == 8'hFF) || (cnt_q < active_duty_q);
    out_d = en_out & (~en_pwm | {16{pwm}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_a_q        <= '0;
      cap_b_q        <= '0;
      stable_q       <= '0;
      pre_q          <= '0;
      cnt_q          <= '0;
      active_duty_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cap_a_q        <= cap_a_d;
      cap_b_q        <= cap_b_d;
      stable_q       <= stable_d;
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      active_duty_q  <= active_duty_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Testbench for pwm_peripheral: two instances (CLK_DIV 12 and 1) share all
// inputs. A history-based model predicts every output after every edge.
module tb_pwm_peripheral;

  localparam int unsigned DIV0 = 12;
  localparam int unsigned DIV1 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out_v = '1;
  logic [15:0] en_pwm_v = '1;
  logic [7:0]  duty_v   = '1;
  logic [15:0] out0, out1;
  logic        ps0, ps1;

  int tests = 0;
  int fails = 0;

  // hist[k] = inputs sampled at the k-th rising edge since reset release.
  logic [39:0] hist[$];
  int          n = 0;

  pwm_peripheral #(.CLK_DIV(DIV0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out_v[7:0]), .en_reg_out_15_8(en_out_v[15:8]),
    .en_reg_pwm_7_0(en_pwm_v[7:0]), .en_reg_pwm_15_8(en_pwm_v[15:8]),
    .pwm_duty_cycle(duty_v), .out(out0), .period_start(ps0)
  );

  pwm_peripheral #(.CLK_DIV(DIV1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out_v[7:0]), .en_reg_out_15_8(en_out_v[15:8]),
    .en_reg_pwm_7_0(en_pwm_v[7:0]), .en_reg_pwm_15_8(en_pwm_v[15:8]),
    .pwm_duty_cycle(duty_v), .out(out1), .period_start(ps1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Last accepted word after edge j: the newest sample s[t] (t <= j-2) that
  // was seen on two consecutive edges.
  function automatic logic [39:0] stable_after(input int j);
    for (int t = j - 2; t >= 1; t--) begin
      if (hist[t] == hist[t+1]) return hist[t];
    end
    return '0;
  endfunction

  function automatic logic [7:0] duty_after(input int div, input int m);
    int p;
    int b;
    logic [39:0] s;
    p = 256 * div;
    if (m < p) return 8'h00;
    b = (m / p) * p;
    s = stable_after(b - 1);
    return s[39:32];
  endfunction

  function automatic logic [15:0] exp_out(input int div, input int k);
    int          m;
    int          c;
    logic [7:0]  d;
    logic [39:0] s;
    logic        hi;
    m  = k - 1;
    c  = (m / div) % 256;
    d  = duty_after(div, m);
    s  = stable_after(m);
    hi = (d == 8'hFF) || (c < int'(d));
    return s[15:0] & (hi ? 16'hFFFF : ~s[31:16]);
  endfunction

  // Edge monitor
  initial begin
    hist.push_back('0);
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        hist.delete();
        hist.push_back('0);
        n = 0;
      end else begin
        hist.push_back({duty_v, en_pwm_v, en_out_v});
        n = n + 1;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_out0", out0, 0);
        check("rst_out1", out1, 0);
        check("rst_ps0", ps0, 0);
        check("rst_ps1", ps1, 0);
      end else if (n >= 1) begin
        check("model_out0", out0, exp_out(DIV0, n));
        check("model_ps0", ps0, (n % (256 * DIV0)) == 0);
        check("model_out1", out1, exp_out(DIV1, n));
        check("model_ps1", ps1, (n % (256 * DIV1)) == 0);
      end
    end
  end

  task automatic set_in(input logic [15:0] o, input logic [15:0] p, input logic [7:0] d);
    @(negedge clk);
    en_out_v = o;
    en_pwm_v = p;
    duty_v   = d;
  endtask

  function automatic logic ps_sel(input int sel);
    return (sel == 0) ? ps0 : ps1;
  endfunction

  task automatic wait_pulse(input int sel);
    int found;
    found = 0;
    for (int k = 0; k < 10000; k++) begin
      if (ps_sel(sel)) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("pulse_wait", found, 1);
  endtask

  // Counts out[0] high samples over one pulse-to-pulse interval.
  task automatic measure(input int sel, input int change_at, input logic [7:0] new_duty,
                         output int highs, output int len, output int first_high);
    logic b0;
    wait_pulse(sel);
    highs = 0;
    len = 0;
    first_high = -1;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      len++;
      b0 = (sel == 0) ? out0[0] : out1[0];
      if (b0) begin
        highs++;
        if (first_high < 0) first_high = len;
      end
      if (len == change_at) duty_v = new_duty;
      if (ps_sel(sel)) break;
    end
  endtask

  task automatic latency_check(input string name, input logic [15:0] o, input logic [15:0] old_v);
    set_in(o, 16'h0000, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check(name, out0, (k < 4) ? old_v : o);
    end
  endtask

  initial begin
    int h, l, f, k0, k1;

    // Reset held with all inputs at ones
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // Enable latency: four clocks
    latency_check("en_latency_ffff", 16'hFFFF, 16'h0000);
    latency_check("en_latency_00f0", 16'h00F0, 16'hFFFF);

    // Duty over one period, CLK_DIV 12
    set_in(16'h0001, 16'h0001, 8'h80);
    repeat (10) @(negedge clk);
    measure(0, 0, 8'h00, h, l, f);
    check("duty80_high", h, 1536);
    check("duty80_len", l, 3072);

    set_in(16'h0001, 16'h0001, 8'hFF);
    repeat (10) @(negedge clk);
    measure(0, 0, 8'h00, h, l, f);
    check("dutyff_high", h, 3072);
    check("dutyff_len", l, 3072);

    set_in(16'h0001, 16'h0001, 8'h00);
    repeat (10) @(negedge clk);
    measure(0, 0, 8'h00, h, l, f);
    check("duty00_high", h, 0);

    // Mid-period duty change: current period keeps the old duty
    set_in(16'h0001, 16'h0001, 8'h40);
    repeat (10) @(negedge clk);
    measure(0, 1000, 8'hC0, h, l, f);
    check("dutychg_old_high", h, 768);
    measure(0, 0, 8'hC0, h, l, f);
    check("dutychg_new_high", h, 2304);

    // Fast toggling is never accepted
    set_in(16'h00FF, 16'h0000, 8'h00);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      en_out_v[8] = ~en_out_v[8];
      check("toggle_hold", out0, 16'h00FF);
    end
    @(negedge clk);
    en_out_v[8] = ~en_out_v[8];
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("toggle_release", out0, (k < 4) ? 16'h00FF : 16'h01FF);
    end

    // CLK_DIV 1, duty 0x01: one high clock right after each pulse
    set_in(16'h0001, 16'h0001, 8'h01);
    repeat (300) @(negedge clk);
    measure(1, 0, 8'h00, h, l, f);
    check("div1_len", l, 256);
    check("div1_high", h, 1);
    check("div1_first_high", f, 1);

    // Randomized phase, checked by the per-cycle compare
    for (int it = 0; it < 60; it++) begin
      int hold;
      logic [7:0] d;
      d = 8'($urandom);
      case ($urandom_range(0, 5))
        0: d = 8'h00;
        1: d = 8'hFF;
        default: ;
      endcase
      set_in(16'($urandom), 16'($urandom), d);
      hold = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 300));
      repeat (hold) @(negedge clk);
    end

    // Asynchronous reset mid-period, then power-on timeline
    set_in(16'hFFFF, 16'h0000, 8'h80);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out0", out0, 0);
    check("async_rst_out1", out1, 0);
    check("async_rst_ps0", ps0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k0 = -1;
    k1 = -1;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (ps1 && k1 < 0) k1 = k;
      if (ps0) begin
        k0 = k;
        break;
      end
    end
    check("first_pulse_div12", k0, 3072);
    check("first_pulse_div1", k1, 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
